// File: rtl/br_scoreboard.sv
// br_scoreboard: a register file with a per-register pending scoreboard,
// a dedicated jump-link write port, and a small bank of 1-bit flags.
// Reads are combinational, and a write in the current cycle is bypassed to
// the read ports. Registers use flip-flops rather than RAM because every
// entry must clear asynchronously on reset.
module br_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NFLAG    = 4,
  parameter int JADDR    = 2**ADDR_W-1,
  parameter int ZERO_REG = 1,
  localparam int FIDX_W  = $clog2(NFLAG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              je,
  input  logic [DATA_W-1:0] jd,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              fe,
  input  logic [FIDX_W-1:0] fidx,
  input  logic              fd,
  input  logic              fclr,
  output logic [NFLAG-1:0]  flags,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] JA = ADDR_W'(JADDR);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  pending_reg;
  logic [DEPTH-1:0]  pend_next;
  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  rsv_hit;
  logic [ADDR_W:0]   cnt_next;
  logic [NFLAG-1:0]  flags_reg;
  logic [NFLAG-1:0]  flags_next;
  logic [ADDR_W:0]   pend_cnt_reg;

  // The general write loses only when it collides with the jump-link write.
  logic gen_wr;
  assign gen_wr = we && !(je && (wa == JA));

  // Per-register write and reservation decode; reservation beats a write.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      localparam bit HARD_ZERO = (ZERO_REG != 0) && (gi == 0);
      assign wr_hit[gi]    = !HARD_ZERO &&
                             ((gen_wr && (wa == ADDR_W'(gi))) || (je && (JA == ADDR_W'(gi))));
      assign rsv_hit[gi]   = !HARD_ZERO && rsv_en && (rsv_addr == ADDR_W'(gi));
      assign pend_next[gi] = rsv_hit[gi] | (pending_reg[gi] & ~wr_hit[gi]);
    end
  endgenerate

  // Population count of the next pending vector, registered as pend_cnt.
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_next = cnt_next + (ADDR_W+1)'(pend_next[i]);
    end
  end

  // Flag update: clear first, then the single-bit write lands on top.
  always_comb begin
    flags_next = fclr ? '0 : flags_reg;
    if (fe && (int'(fidx) < NFLAG)) begin
      flags_next[fidx] = fd;
    end
  end

  // All architectural state: register file, pending bits, count and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      pending_reg  <= '0;
      pend_cnt_reg <= '0;
      flags_reg    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit[i]) begin
          mem_reg[i] <= (je && (JA == ADDR_W'(i))) ? jd : wd;
        end
      end
      pending_reg  <= pend_next;
      pend_cnt_reg <= cnt_next;
      flags_reg    <= flags_next;
    end
  end

  // Two identical read ports with write bypass and busy qualification.
  logic [1:0][ADDR_W-1:0] ra_vec;
  logic [1:0][DATA_W-1:0] rd_vec;
  logic [1:0]             busy_vec;
  assign ra_vec = {ra2, ra1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic hit_j;
      logic hit_w;
      logic is_zero;
      assign hit_j   = je && (ra_vec[gi] == JA);
      assign hit_w   = we && (ra_vec[gi] == wa);
      assign is_zero = (ZERO_REG != 0) && (ra_vec[gi] == '0);
      assign rd_vec[gi] = (is_zero || rst) ? '0 :
                          hit_j            ? jd :
                          hit_w            ? wd :
                                             mem_reg[ra_vec[gi]];
      assign busy_vec[gi] = !is_zero && !rst && pending_reg[ra_vec[gi]] && !(hit_j || hit_w);
    end
  endgenerate

  assign rd1      = rd_vec[0];
  assign rd2      = rd_vec[1];
  assign busy1    = busy_vec[0];
  assign busy2    = busy_vec[1];
  assign flags    = flags_reg;
  assign pend_cnt = pend_cnt_reg;

endmodule

// File: tb/tb_br_scoreboard.sv
// Directed plus short random bench for br_scoreboard with default parameters.
// Expected values are pushed to a queue as stimulus is applied and popped
// when the corresponding DUT output is sampled.
module tb_br_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra1, ra2, wa, rsv_addr;
  logic [31:0] rd1, rd2, wd, jd;
  logic        busy1, busy2, we, je, rsv_en, fe, fd, fclr;
  logic [1:0]  fidx;
  logic [3:0]  flags;
  logic [5:0]  pend_cnt;

  br_scoreboard dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .we(we), .wa(wa), .wd(wd), .je(je), .jd(jd),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .fe(fe), .fidx(fidx), .fd(fd),
    .fclr(fclr), .flags(flags), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural reference state for the random phase.
  logic [31:0] m_mem [32];
  logic [31:0] m_pend;

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL queue_empty observed=%h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
      $display("[%0t] %s observed=%h expected=%h", $time, e.tag, obs, e.val);
    end
  endtask

  task automatic idle();
    we = 0; je = 0; rsv_en = 0; fe = 0; fclr = 0;
  endtask

  // Wait for the rising edge, then let outputs settle with inputs idled.
  task automatic edge_then_idle();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (je && a == 5'd31) return jd;
    if (we && a == wa) return wd;
    return m_mem[a];
  endfunction

  function automatic int popc(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction

  initial begin
    rst = 1; ra1 = 0; ra2 = 0; wa = 0; wd = 0; jd = 0; rsv_addr = 0; fidx = 0; fd = 0;
    idle();
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
    m_pend = 0;
    repeat (2) @(negedge clk);

    // Reset state, with a write attempted under reset (no bypass, ignored).
    we = 1; wa = 3; wd = 32'h123; ra1 = 3;
    #1;
    push("rst_rd1", 0);    chk(rd1);
    push("rst_busy1", 0);  chk(busy1);
    push("rst_cnt", 0);    chk(pend_cnt);
    push("rst_flags", 0);  chk(flags);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 0; idle();
    #1;
    push("rst_wr_ignored", 0); chk(rd1);

    // Bypass of a general write, then the stored value.
    @(negedge clk);
    we = 1; wa = 3; wd = 32'hDEADBEEF; ra1 = 3;
    #1;
    push("byp_rd1", 32'hDEADBEEF); chk(rd1);
    edge_then_idle();
    push("stored_rd1", 32'hDEADBEEF); chk(rd1);
    push("stored_busy1", 0);          chk(busy1);
    m_mem[3] = 32'hDEADBEEF;

    // Collision of general and jump-link writes on JADDR: jump-link wins.
    @(negedge clk);
    we = 1; wa = 31; wd = 32'h11; je = 1; jd = 32'h22; ra1 = 31;
    #1;
    push("jcol_byp", 32'h22); chk(rd1);
    edge_then_idle();
    push("jcol_stored", 32'h22); chk(rd1);
    m_mem[31] = 32'h22;

    // Non-colliding dual write: both land.
    @(negedge clk);
    we = 1; wa = 4; wd = 32'h44; je = 1; jd = 32'h55; ra1 = 4; ra2 = 31;
    #1;
    push("dual_byp_rd1", 32'h44); chk(rd1);
    push("dual_byp_rd2", 32'h55); chk(rd2);
    edge_then_idle();
    push("dual_rd1", 32'h44); chk(rd1);
    push("dual_rd2", 32'h55); chk(rd2);
    m_mem[4] = 32'h44; m_mem[31] = 32'h55;

    // Reserve 5, reserve again, then write it.
    @(negedge clk);
    rsv_en = 1; rsv_addr = 5; ra1 = 5;
    #1;
    push("rsv_busy_same_cycle", 0); chk(busy1);
    edge_then_idle();
    push("rsv_busy", 1); chk(busy1);
    push("rsv_cnt", 1);  chk(pend_cnt);
    @(negedge clk);
    rsv_en = 1; rsv_addr = 5;
    edge_then_idle();
    push("rsv2_cnt", 1); chk(pend_cnt);
    @(negedge clk);
    we = 1; wa = 5; wd = 7;
    #1;
    push("wr5_busy", 0); chk(busy1);
    push("wr5_rd1", 7);  chk(rd1);
    edge_then_idle();
    push("wr5_cnt", 0); chk(pend_cnt);
    push("wr5_busy_after", 0); chk(busy1);
    m_mem[5] = 7;

    // Simultaneous reservation and write to 9: data lands, stays pending.
    @(negedge clk);
    rsv_en = 1; rsv_addr = 9; we = 1; wa = 9; wd = 32'h99; ra1 = 9;
    edge_then_idle();
    push("rw9_rd1", 32'h99); chk(rd1);
    push("rw9_busy", 1);     chk(busy1);
    push("rw9_cnt", 1);      chk(pend_cnt);
    @(negedge clk);
    we = 1; wa = 9; wd = 32'h9A;
    edge_then_idle();
    push("clr9_cnt", 0); chk(pend_cnt);
    m_mem[9] = 32'h9A;

    // Jump-link write clears a reservation on JADDR and un-busies the read.
    @(negedge clk);
    rsv_en = 1; rsv_addr = 31; ra2 = 31;
    edge_then_idle();
    push("rsv31_busy2", 1); chk(busy2);
    @(negedge clk);
    je = 1; jd = 32'h77;
    #1;
    push("je_busy2", 0); chk(busy2);
    edge_then_idle();
    push("je_cnt", 0);    chk(pend_cnt);
    push("je_rd2", 32'h77); chk(rd2);
    m_mem[31] = 32'h77;

    // Register 0 ignores writes and reservations.
    @(negedge clk);
    we = 1; wa = 0; wd = 32'hFFFF; rsv_en = 1; rsv_addr = 0; ra1 = 0;
    #1;
    push("z_byp_rd1", 0); chk(rd1);
    push("z_busy1", 0);   chk(busy1);
    edge_then_idle();
    push("z_rd1", 0);  chk(rd1);
    push("z_cnt", 0);  chk(pend_cnt);

    // Flags: build 1010, then clear+write in one cycle.
    @(negedge clk);
    fe = 1; fidx = 1; fd = 1;
    edge_then_idle();
    @(negedge clk);
    fe = 1; fidx = 3; fd = 1;
    edge_then_idle();
    push("flags_1010", 4'b1010); chk(flags);
    @(negedge clk);
    fclr = 1; fe = 1; fidx = 0; fd = 1;
    #1;
    push("flags_no_bypass", 4'b1010); chk(flags);
    edge_then_idle();
    push("flags_clr_wr", 4'b0001); chk(flags);

    // Asynchronous reset between edges with a reservation outstanding.
    @(negedge clk);
    rsv_en = 1; rsv_addr = 6;
    edge_then_idle();
    push("pre_rst_cnt", 1); chk(pend_cnt);
    @(negedge clk);
    #1;
    rst = 1;
    #1;
    push("arst_flags", 0); chk(flags);
    push("arst_cnt", 0);   chk(pend_cnt);
    ra1 = 3;
    #1;
    push("arst_rd1", 0);   chk(rd1);
    rst = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
    m_pend = 0;
    @(negedge clk);
    we = 1; wa = 3; wd = 32'hAA; ra2 = 6;
    edge_then_idle();
    push("post_rst_rd1", 32'hAA); chk(rd1);
    push("post_rst_busy2", 0);    chk(busy2);
    m_mem[3] = 32'hAA;

    // Random traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] nxt_pend;
      @(negedge clk);
      we = 1'($urandom_range(0, 1)); wa = 5'($urandom_range(0, 31)); wd = $urandom;
      je = ($urandom_range(0, 3) == 0); jd = $urandom;
      rsv_en = 1'($urandom_range(0, 1)); rsv_addr = 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 1) == 1) ? wa : 5'($urandom_range(0, 31));
      ra2 = 5'($urandom_range(0, 31));
      #1;
      push("rnd_rd1", m_rd(ra1)); chk(rd1);
      push("rnd_busy2", (ra2 != 0 && m_pend[ra2] &&
                         !((je && ra2 == 5'd31) || (we && ra2 == wa))) ? 1 : 0);
      chk(busy2);
      nxt_pend = m_pend;
      if (we && wa != 0 && !(je && wa == 5'd31)) begin
        m_mem[wa] = wd; nxt_pend[wa] = 0;
      end
      if (je) begin
        m_mem[31] = jd; nxt_pend[31] = 0;
      end
      if (rsv_en && rsv_addr != 0) nxt_pend[rsv_addr] = 1;
      m_pend = nxt_pend;
      edge_then_idle();
      push("rnd_cnt", popc(m_pend)); chk(pend_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
